// File: rtl/scaler_line_buffer.sv
// scaler_line_buffer: ring of NUM_LINES line stores feeding the scaler's
// vertical filter. The write side fills one line at a time (explicit wr_eol or
// implicit end at the last column). The read side sees TAPS vertically adjacent
// pixels of one column, starting at the oldest held line.
// Optional build macro: SCALER_LB_OUTREG_EN adds a second rd_data register
// stage, so read latency becomes 2 cycles.
module scaler_line_buffer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int NUM_LINES = 4,
  parameter int TAPS      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_eol,
  output logic                     win_valid,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [TAPS*DATA_W-1:0]   rd_data,
  output logic [ADDR_W:0]          rd_len,
  input  logic                     rd_line_done,
  output logic                     err
);

  localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int CNT_W  = $clog2(NUM_LINES + 1);
  localparam int DEPTH  = 1 << ADDR_W;

  logic [DATA_W-1:0]      mem [NUM_LINES][DEPTH];
  logic [ADDR_W:0]        len [NUM_LINES];
  logic [LINE_W-1:0]      wr_line;
  logic [LINE_W-1:0]      rd_base;
  logic [ADDR_W-1:0]      wr_col;
  logic [CNT_W-1:0]       lines_avail;
  logic                   err_q;
  logic                   wr_acc;
  logic                   line_close;
  logic                   line_rel;
  logic [TAPS*DATA_W-1:0] rd_data_p1;

  // Advance a ring pointer, wrapping after the last line store.
  function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] p);
    return (p == LINE_W'(NUM_LINES - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ring slot holding window line k (k < NUM_LINES, so one wrap suffices).
  function automatic logic [LINE_W-1:0] ring_idx(input logic [LINE_W-1:0] base,
                                                 input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_LINES) s = s - NUM_LINES;
    return LINE_W'(s);
  endfunction

  // The slot being filled is never counted as held, so it cannot be in the window.
  assign wr_ready   = (lines_avail < CNT_W'(NUM_LINES));
  assign win_valid  = (lines_avail >= CNT_W'(TAPS));
  assign wr_acc     = wr_valid & wr_ready & ~flush;
  assign line_close = wr_acc & (wr_eol | (wr_col == '1));
  assign line_rel   = rd_line_done & win_valid & ~flush;
  assign rd_len     = len[rd_base];
  assign err        = err_q;

  // Pointers, occupancy, per-line lengths and the sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_line     <= '0;
      rd_base     <= '0;
      wr_col      <= '0;
      lines_avail <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) len[i] <= '0;
    end else if (flush) begin
      wr_line     <= '0;
      rd_base     <= '0;
      wr_col      <= '0;
      lines_avail <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) len[i] <= '0;
    end else begin
      if (wr_acc) begin
        if (line_close) begin
          len[wr_line] <= {1'b0, wr_col} + 1'b1;
          wr_col       <= '0;
          wr_line      <= next_line(wr_line);
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      if (line_rel) rd_base <= next_line(rd_base);
      case ({line_close, line_rel})
        2'b10:   lines_avail <= lines_avail + 1'b1;
        2'b01:   lines_avail <= lines_avail - 1'b1;
        default: lines_avail <= lines_avail;
      endcase
      if ((rd_en | rd_line_done) & ~win_valid) err_q <= 1'b1;
    end
  end

  // Pixel store; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_line][wr_col] <= wr_data;
  end

  // ---- read stage p1: fetch TAPS pixels of one column, slice 0 = oldest line
  // Read register; holds its value when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
    end else if (flush) begin
      rd_data_p1 <= '0;
    end else if (rd_en) begin
      for (int k = 0; k < TAPS; k++)
        rd_data_p1[k*DATA_W +: DATA_W] <= mem[ring_idx(rd_base, k)][rd_addr];
    end
  end

`ifdef SCALER_LB_OUTREG_EN
  logic                   vld_p1;
  logic [TAPS*DATA_W-1:0] rd_data_p2;

  // ---- read stage p2: optional output register, loaded only behind a real read
  // Output register stage, enabled by the delayed read request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      rd_data_p2 <= '0;
    end else if (flush) begin
      vld_p1     <= 1'b0;
      rd_data_p2 <= '0;
    end else begin
      vld_p1 <= rd_en;
      if (vld_p1) rd_data_p2 <= rd_data_p1;
    end
  end

  assign rd_data = rd_data_p2;
`else
  assign rd_data = rd_data_p1;
`endif

endmodule

// File: tb/tb_scaler_line_buffer.sv
// tb_scaler_line_buffer: directed scenarios plus randomized traffic, checked
// every cycle against a line-level behavioural model of the buffer.
module tb_scaler_line_buffer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 11;
  localparam int NL     = 4;
  localparam int TAPS   = 2;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef SCALER_LB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic                   wr_valid = 1'b0;
  logic                   wr_ready;
  logic [DATA_W-1:0]      wr_data = '0;
  logic                   wr_eol = 1'b0;
  logic                   win_valid;
  logic                   rd_en = 1'b0;
  logic [ADDR_W-1:0]      rd_addr = '0;
  logic [TAPS*DATA_W-1:0] rd_data;
  logic [ADDR_W:0]        rd_len;
  logic                   rd_line_done = 1'b0;
  logic                   err;

  int n_cmp = 0;
  int n_err = 0;

  scaler_line_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_LINES(NL), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_eol(wr_eol),
    .win_valid(win_valid), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_len(rd_len), .rd_line_done(rd_line_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pixel storage per ring slot (-1 = never written), stored line lengths,
  // write slot/column, number of complete lines held, sticky error.
  int mmem [NL][DEPTH];
  int mlen [NL];
  int mwr, mcol, mn;
  bit merr;
  int exp_rd [TAPS];
  int exp_st [TAPS];
  bit st_en;

  // The oldest held line sits mn slots behind the slot being written.
  function automatic int mbase();
    return (mwr + NL - mn) % NL;
  endfunction

  task automatic mclear();
    mwr = 0; mcol = 0; mn = 0; merr = 0; st_en = 0;
    for (int i = 0; i < NL; i++) mlen[i] = 0;
    for (int k = 0; k < TAPS; k++) begin exp_rd[k] = 0; exp_st[k] = 0; end
  endtask

  initial begin
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < DEPTH; j++) mmem[i][j] = -1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclear();
    end else if (flush) begin
      mclear();
    end else begin
      int b, cl, rl;
      int nr [TAPS];
      bit rv;
      b  = mbase();
      rv = (mn >= TAPS);
      cl = 0;
      for (int k = 0; k < TAPS; k++) nr[k] = mmem[(b + k) % NL][int'(rd_addr)];
      if (rd_en && !rv) merr = 1;
`ifdef SCALER_LB_OUTREG_EN
      if (st_en) exp_rd = exp_st;
      if (rd_en) exp_st = nr;
      st_en = rd_en;
`else
      if (rd_en) exp_rd = nr;
`endif
      rl = (rd_line_done && rv) ? 1 : 0;
      if (rd_line_done && !rv) merr = 1;
      if (wr_valid && mn < NL) begin
        mmem[mwr][mcol] = int'(wr_data);
        if (wr_eol || mcol == DEPTH - 1) begin
          mlen[mwr] = mcol + 1;
          mwr = (mwr + 1) % NL;
          mcol = 0;
          cl = 1;
        end else begin
          mcol++;
        end
      end
      mn = mn + cl - rl;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int b;
    b = mbase();
    chk("wr_ready", 32'(wr_ready), 32'(mn < NL));
    chk("win_valid", 32'(win_valid), 32'(mn >= TAPS));
    chk("rd_len", 32'(rd_len), 32'(mlen[b]));
    chk("err", 32'(err), 32'(merr));
    for (int k = 0; k < TAPS; k++)
      if (exp_rd[k] >= 0) chk("rd_data", 32'(rd_data[k*DATA_W +: DATA_W]), 32'(exp_rd[k]));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic e, input bit gaps);
    int guard;
    guard = 0;
    if (gaps && ($urandom % 4 == 0)) step();
    wr_valid = 1'b1; wr_data = d; wr_eol = e;
    while (!wr_ready && guard < 100) begin step(); guard++; end
    if (guard >= 100) chk("wr_ready_timeout", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0; wr_eol = 1'b0;
  endtask

  task automatic put_line(input int base, input int n);
    for (int c = 0; c < n; c++) put(8'(base + c), (c == n - 1), 1'b1);
  endtask

  task automatic do_read(input int addr);
    rd_en = 1'b1; rd_addr = ADDR_W'(addr);
    step();
    rd_en = 1'b0;
    repeat (LAT - 1) step();
  endtask

  task automatic pulse_done();
    rd_line_done = 1'b1; step(); rd_line_done = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) step();
    chk("reset_wr_ready", 32'(wr_ready), 32'd1);
    chk("reset_win_valid", 32'(win_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_rd_len", 32'(rd_len), 32'd0);
    rst_n = 1'b1;
    step();

    // Four lines of 16 pixels, value line*16+col
    put_line(8'h00, 16);
    chk("win_valid_after_l0", 32'(win_valid), 32'd0);
    put_line(8'h10, 16);
    chk("win_valid_after_l1", 32'(win_valid), 32'd1);
    put_line(8'h20, 16);
    chk("wr_ready_after_l2", 32'(wr_ready), 32'd1);
    put_line(8'h30, 16);
    chk("wr_ready_full", 32'(wr_ready), 32'd0);
    do_read(5);
    chk("read_col5", 32'(rd_data), 32'h1505);
    chk("read_ok_err", 32'(err), 32'd0);

    // Release one line, fifth line lands in slot 0
    pulse_done();
    chk("wr_ready_after_done", 32'(wr_ready), 32'd1);
    do_read(3);
    chk("read_col3", 32'(rd_data), 32'h2313);
    chk("rd_len_16", 32'(rd_len), 32'd16);
    put_line(8'h40, 16);
    chk("full_again", 32'(wr_ready), 32'd0);

    // Down to 2 held lines, then close a line while releasing one
    pulse_done();
    pulse_done();
    for (int c = 0; c < 15; c++) put(8'(8'h50 + c), 1'b0, 1'b1);
    wr_valid = 1'b1; wr_data = 8'h5f; wr_eol = 1'b1; rd_line_done = 1'b1;
    step();
    wr_valid = 1'b0; wr_eol = 1'b0; rd_line_done = 1'b0;
    chk("simul_win_valid", 32'(win_valid), 32'd1);
    chk("simul_wr_ready", 32'(wr_ready), 32'd1);
    do_read(3);
    chk("simul_read_col3", 32'(rd_data), 32'h5343);
    pulse_done();
    chk("simul_count_two", 32'(win_valid), 32'd0);

    // Implicit end of line at full length
    pulse_flush();
    for (int c = 0; c < DEPTH; c++) put(8'($urandom), 1'b0, 1'b0);
    chk("implicit_len", 32'(rd_len), 32'd2048);
    chk("implicit_win", 32'(win_valid), 32'd0);
    put(8'hA5, 1'b1, 1'b0);
    pulse_done();
    chk("wrap_col0_len", 32'(rd_len), 32'd1);

    // Protocol error, then asynchronous reset mid-line
    pulse_flush();
    pulse_done();
    chk("err_set", 32'(err), 32'd1);
    chk("err_win_valid", 32'(win_valid), 32'd0);
    put(8'h11, 1'b0, 1'b0);
    put(8'h22, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_err_clear", 32'(err), 32'd0);
    chk("async_wr_ready", 32'(wr_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    put_line(8'h60, 3);
    chk("after_reset_len3", 32'(rd_len), 32'd3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_valid     = ($urandom % 3 != 0);
      wr_data      = 8'($urandom);
      wr_eol       = ($urandom % 12 == 0);
      rd_en        = ($urandom % 2 == 0);
      rd_addr      = ADDR_W'($urandom % 24);
      rd_line_done = ($urandom % 8 == 0);
      flush        = ($urandom % 300 == 0);
      step();
    end
    wr_valid = 1'b0; wr_eol = 1'b0; rd_en = 1'b0; rd_line_done = 1'b0; flush = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
